// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: measures VGA line/frame timing, tracks lock, flags errors.
// Ports: vga_clk, sys_rst, vga_hs, vga_vs, vga_rgb, err_clr in; h_len, v_len,
// frame_done, locked, err_h, err_v, frame_cnt, frame_sum, sum_valid out.
// Optional active-pixel checksum: define VGA_MON_FRAME_SUM_EN.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 4,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_LEN   = 640,
  parameter int V_ACT_START = 36,
  parameter int V_ACT_LEN   = 480
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [23:0] vga_rgb,
  input  logic        err_clr,
  output logic [11:0] h_len,
  output logic [11:0] v_len,
  output logic        frame_done,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] frame_cnt,
  output logic [23:0] frame_sum,
  output logic        sum_valid
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  state_t      state, state_n;
  logic [7:0]  gc, gc_n;
  logic        hs_d, vs_d;
  logic        hs_fall, vs_fall, act;
  logic [11:0] hcnt, vcnt;
  logic [12:0] h_meas;
  logic        line_ok, frame_bad;
  logic        h_mis, h_to, v_mis, v_to;
  logic        bad, good;

  assign hs_fall = hs_d & ~vga_hs;
  assign vs_fall = vs_d & ~vga_vs;
  assign act     = (state != IDLE);
  assign locked  = (state == LOCKED);
  assign h_meas  = {1'b0, hcnt} + 13'd1;

  assign h_mis = act & hs_fall & line_ok
               & (h_meas != 13'(H_TOTAL));
  // Flag the edge on which a counter climbs into saturation.
  assign h_to  = act & ~hs_fall & (hcnt == 12'd4094);
  assign v_mis = act & vs_fall & (vcnt != 12'(V_TOTAL));
  assign v_to  = act & hs_fall & ~vs_fall
               & (vcnt == 12'd4094);
  assign bad   = h_mis | h_to | v_mis | v_to;
  // A frame counts only if nothing went wrong anywhere inside it.
  assign good  = vs_fall & ~bad & ~frame_bad;

  always_comb begin
    state_n = state;
    gc_n    = gc;
    unique case (state)
      IDLE: begin
        if (vs_fall) begin
          state_n = TRACK;
          gc_n    = '0;
        end
      end
      TRACK: begin
        if (bad) begin
          gc_n = '0;
        end else if (good) begin
          gc_n = gc + 8'd1;
          if (gc + 8'd1 == LOCK_N) state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_n = TRACK;
          gc_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gc_n    = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      gc         <= '0;
      hs_d       <= 1'b1;
      vs_d       <= 1'b1;
      hcnt       <= '0;
      vcnt       <= '0;
      line_ok    <= 1'b0;
      frame_bad  <= 1'b0;
      h_len      <= '0;
      v_len      <= '0;
      err_h      <= 1'b0;
      err_v      <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state <= state_n;
      gc    <= gc_n;
      hs_d  <= vga_hs;
      vs_d  <= vga_vs;
      if (hs_fall) hcnt <= '0;
      else if (hcnt != 12'hFFF) hcnt <= hcnt + 12'd1;
      if (vs_fall) vcnt <= hs_fall ? 12'd1 : 12'd0;
      else if (hs_fall && vcnt != 12'hFFF)
        vcnt <= vcnt + 12'd1;
      // The partial line in flight when tracking starts,
      // and a line that timed out, are never measured.
      if (hs_fall) line_ok <= act;
      else if (h_to) line_ok <= 1'b0;
      if (hs_fall && act && line_ok) h_len <= h_meas[11:0];
      if (vs_fall && act) v_len <= vcnt;
      // A new error outranks a simultaneous clear.
      err_h <= (err_h & ~err_clr) | h_mis | h_to;
      err_v <= (err_v & ~err_clr) | v_mis | v_to;
      if (vs_fall) frame_bad <= 1'b0;
      else if (bad) frame_bad <= 1'b1;
      frame_done <= act & vs_fall;
      if (act && vs_fall) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef VGA_MON_FRAME_SUM_EN
  logic [23:0] acc;
  logic        in_win;

  assign in_win =
    (hcnt >= 12'(H_ACT_START)) &&
    (hcnt <= 12'(H_ACT_START + H_ACT_LEN - 1)) &&
    (vcnt >= 12'(V_ACT_START)) &&
    (vcnt <= 12'(V_ACT_START + V_ACT_LEN - 1));

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc       <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= act & vs_fall;
      // Restart on every vs fall so the first tracked frame is clean.
      if (vs_fall) begin
        acc <= '0;
        if (act) frame_sum <= acc;
      end else if (in_win) begin
        acc <= acc + vga_rgb;
      end
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^vga_rgb;
  assign frame_sum  = '0;
  assign sum_valid  = 1'b0;
`endif

endmodule
